hash_row_dispatch_scheduler: RTL
================================

HASH_ROW_DISPATCH_SCHEDULER -- requirements
Module: hash_row_dispatch_scheduler

Interface
REQ-001 The block SHALL take widths HASH_ISSUE_WIDTH (H), ROW_SIZE (R) and ADDR_WIDTH (A) from parameters.vh.
REQ-002 Parameter CREDIT_W, default 4: width of the credit counter.
REQ-003 Parameter CREDIT_INIT, default 8: number of downstream PE job slots; SHALL be at most 2^CREDIT_W-1.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 in_valid  in  1  row bundle valid.
REQ-007 in_head_addr  in  A  head address of the bundle.
REQ-008 in_row_valid  in  H  per-row valid.
REQ-009 in_history_valid_vec  in  H*R  per-row history valid; row i at [i*R +: R].
REQ-010 in_history_addr_vec  in  H*R*A  per-row history addresses; row i at [i*R*A +: R*A].
REQ-011 in_delim  in  1  end-of-block delimiter.
REQ-012 in_ready  out  1  bundle accept.
REQ-013 job_valid  out  1  single-row job valid.
REQ-014 job_addr  out  A  address of the job's row.
REQ-015 job_history_valid  out  R  history valid for the job's row.
REQ-016 job_history_addr  out  R*A  history addresses for the job's row.
REQ-017 job_last  out  1  last job of the bundle.
REQ-018 job_delim  out  1  delimiter; asserted only together with job_last.
REQ-019 job_ready  in  1  job accept.
REQ-020 credit_return  in  1  single-cycle pulse; the PE freed one slot.
REQ-021 credit_cnt  out  CREDIT_W  current credits.
REQ-022 credit_err  out  1  sticky credit-overflow error.

Function
REQ-023 A handshake SHALL occur when valid and ready are both high at a rising clk edge, on both the in_ and job_ ports.
REQ-024 The FSM SHALL have two states, IDLE and ISSUE.
REQ-025 in_ready SHALL be high exactly when the state is IDLE and rst is low.
REQ-026 On an input handshake the block SHALL register head_addr, history vectors and delim, and load pending mask = in_row_valid.
REQ-027 On the same handshake the state SHALL go to ISSUE, except for a bundle with in_row_valid==0 and in_delim==0.
REQ-028 A bundle with in_row_valid==0 and in_delim==0 SHALL be consumed, produce no job, and leave the state IDLE.
REQ-029 A bundle with in_row_valid==0 and in_delim==1 SHALL produce exactly one job.
  - index 0, job_history_valid=0, job_last=1, job_delim=1.
REQ-030 In ISSUE, the selected row SHALL be the lowest-index set bit of the pending mask (index 0 when the mask is empty).
REQ-031 job_valid SHALL equal (state==ISSUE) && (credit_cnt!=0).
REQ-032 Job address: job_addr = captured head_addr + index, truncated modulo 2^A (wrap-around allowed).
REQ-033 job_history_valid and job_history_addr SHALL be the captured slices of the selected row.
REQ-034 job_last SHALL be high when at most one pending bit remains.
REQ-035 job_delim SHALL equal captured delim AND job_last.
REQ-036 All job_* payloads SHALL come from registered state only, with no combinational path from in_*.
REQ-037 The job payload SHALL stay stable while job_valid is high and job_ready is low.
REQ-038 On a job handshake the selected pending bit SHALL clear.
REQ-039 A job handshake with job_last=1 SHALL return the state to IDLE.
  - Next bundle accept is earliest one cycle later, so there is no overlap between bundles.
REQ-040 The first job_valid SHALL assert the cycle after the input handshake, provided credits are nonzero; sustained throughput is one job per cycle.
REQ-041 Credit update rules:
  - job handshake alone: credit_cnt decrements by 1.
  - credit_return alone: credit_cnt increments by 1.
  - both in the same cycle: credit_cnt unchanged.
REQ-042 credit_cnt SHALL never exceed CREDIT_INIT.
  - A lone credit_return at CREDIT_INIT leaves the count unchanged and sets credit_err.
REQ-043 credit_err SHALL clear only on reset.
REQ-044 When credit_cnt==0, job_valid SHALL stay low and the pending state SHALL hold.
  - A credit_return re-enables job_valid on the next cycle.

Reset
REQ-045 While rst is high, the following SHALL hold asynchronously:
  - state=IDLE, pending=0, credit_cnt=CREDIT_INIT, credit_err=0.
  - job_valid=0, in_ready=0.
  - captured payload registers=0, so job_addr=0, job_history_valid=0, job_history_addr=0, job_last=0 and job_delim=0.
REQ-046 Reset asserted mid-bundle SHALL discard the remaining pending rows with no partial job emitted afterward.
REQ-047 in_ready SHALL be high in the first cycle after rst deasserts.

Verification
REQ-048 H=4. Bundle head=0x100, row_valid=4'b1010, delim=1, job_ready=1 -> jobs addr 0x101 (last=0) then 0x103 (last=1, delim=1) on consecutive cycles; in_ready low for 2 cycles.
REQ-049 Empty bundles: row_valid=0, delim=0 -> no job, in_ready stays high; row_valid=0, delim=1 -> one job, addr=head, history_valid=0, last=1, delim=1.
REQ-050 CREDIT_INIT=2, row_valid=4'b1111, no credit_return -> 2 jobs issued, then job_valid=0 with credit_cnt=0; one credit_return pulse -> third job next cycle.
REQ-051 head=2^A-1, row_valid=4'b0011 -> job_addr=2^A-1, then 0.
REQ-052 credit_return and job handshake in the same cycle -> credit_cnt unchanged; credit_return at credit_cnt=CREDIT_INIT -> credit_err=1, count unchanged.
REQ-053 Backpressure then reset: job_ready=0 for 5 cycles -> payload stable; rst asserted mid-bundle -> job_valid=0 immediately, credit_cnt=CREDIT_INIT, in_ready=1 after release.

Source files
------------

// File: rtl/hash_row_dispatch_scheduler.sv
// hash_row_dispatch_scheduler -- splits a row bundle into credit-gated single-row jobs.
// Rev 1.0
`default_nettype none

module hash_row_dispatch_scheduler #(
  parameter int HASH_ISSUE_WIDTH = 4,
  parameter int ROW_SIZE         = 2,
  parameter int ADDR_WIDTH       = 12,
  parameter int CREDIT_W         = 4,
  parameter int CREDIT_INIT      = 8
) (
  input  logic                                        clk,
  input  logic                                        rst,
  input  logic                                        in_valid,
  input  logic [ADDR_WIDTH-1:0]                       in_head_addr,
  input  logic [HASH_ISSUE_WIDTH-1:0]                 in_row_valid,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE-1:0]        in_history_valid_vec,
  input  logic [HASH_ISSUE_WIDTH*ROW_SIZE*ADDR_WIDTH-1:0] in_history_addr_vec,
  input  logic                                        in_delim,
  output logic                                        in_ready,
  output logic                                        job_valid,
  output logic [ADDR_WIDTH-1:0]                       job_addr,
  output logic [ROW_SIZE-1:0]                         job_history_valid,
  output logic [ROW_SIZE*ADDR_WIDTH-1:0]              job_history_addr,
  output logic                                        job_last,
  output logic                                        job_delim,
  input  logic                                        job_ready,
  input  logic                                        credit_return,
  output logic [CREDIT_W-1:0]                         credit_cnt,
  output logic                                        credit_err
);

  localparam int H  = HASH_ISSUE_WIDTH;
  localparam int R  = ROW_SIZE;
  localparam int A  = ADDR_WIDTH;
  localparam int IW = (H > 1) ? $clog2(H) : 1;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_t;

  state_t              state_q;
  logic [A-1:0]        head_q;
  logic [H*R-1:0]      hv_q;
  logic [H*R*A-1:0]    ha_q;
  logic                delim_q;
  logic [H-1:0]        pend_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CREDIT_W-1:0] credit_d;
  logic                err_q;
  logic                ovf;
  logic [IW-1:0]       sel_idx;
  logic [H*R-1:0]      hv_masked;
  logic                in_hs;
  logic                job_hs;

  // Lowest pending row wins; an empty mask falls through to row 0.
  always_comb begin
    sel_idx = '0;
    for (int i = H - 1; i >= 0; i--) begin
      if (pend_q[i]) sel_idx = IW'(i);
    end
  end

  // History valid of rows not flagged in in_row_valid is dropped at capture,
  // so a delimiter-only bundle carries an all-zero history.
  always_comb begin
    hv_masked = '0;
    for (int i = 0; i < H; i++) begin
      hv_masked[i*R +: R] = in_history_valid_vec[i*R +: R] & {R{in_row_valid[i]}};
    end
  end

  assign in_ready          = (state_q == IDLE) && !rst;
  assign job_valid         = (state_q == ISSUE) && (credit_q != '0);
  assign job_addr          = head_q + A'(sel_idx);
  assign job_history_valid = hv_q[sel_idx*R +: R];
  assign job_history_addr  = ha_q[sel_idx*R*A +: R*A];
  assign job_last          = (state_q == ISSUE) && ((pend_q & (pend_q - H'(1))) == '0);
  assign job_delim         = delim_q && job_last;
  assign credit_cnt        = credit_q;
  assign credit_err        = err_q;

  assign in_hs  = in_valid && in_ready;
  assign job_hs = job_valid && job_ready;

  always_comb begin
    credit_d = credit_q;
    ovf      = 1'b0;
    if (job_hs && !credit_return) begin
      credit_d = credit_q - CREDIT_W'(1);
    end else if (credit_return && !job_hs) begin
      if (credit_q == CREDIT_W'(CREDIT_INIT)) ovf = 1'b1;
      else                                    credit_d = credit_q + CREDIT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      head_q   <= '0;
      hv_q     <= '0;
      ha_q     <= '0;
      delim_q  <= 1'b0;
      pend_q   <= '0;
      credit_q <= CREDIT_W'(CREDIT_INIT);
      err_q    <= 1'b0;
    end else begin
      credit_q <= credit_d;
      if (ovf) err_q <= 1'b1;
      case (state_q)
        IDLE: begin
          if (in_hs) begin
            head_q  <= in_head_addr;
            hv_q    <= hv_masked;
            ha_q    <= in_history_addr_vec;
            delim_q <= in_delim;
            pend_q  <= in_row_valid;
            if ((in_row_valid != '0) || in_delim) state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (job_hs) begin
            pend_q[sel_idx] <= 1'b0;
            if (job_last) state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
